// File: rtl/dbus_split.sv
// Routes one load/store requester to data memory (port 0) or MMIO (port 1), one transaction at a time.
// Define DBUS_SPLIT_ERR_EN to flag addresses outside both regions as decode errors instead of sending them to port 0.
module dbus_split #(
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
  parameter logic [31:0] MMIO_MASK = 32'hF000_0000,
  parameter logic [31:0] MEM_SIZE  = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        up_req_valid,
  output logic        up_req_ready,
  input  logic [31:0] up_addr,
  input  logic [31:0] up_wdata,
  input  logic        up_we,
  input  logic [3:0]  up_be,
  output logic        up_rsp_valid,
  output logic [31:0] up_rsp_rdata,
  output logic        up_rsp_err,
  output logic        d0_req_valid,
  input  logic        d0_req_ready,
  output logic [31:0] d0_addr,
  output logic [31:0] d0_wdata,
  output logic        d0_we,
  output logic [3:0]  d0_be,
  input  logic        d0_rsp_valid,
  input  logic [31:0] d0_rsp_rdata,
  output logic        d1_req_valid,
  input  logic        d1_req_ready,
  output logic [31:0] d1_addr,
  output logic [31:0] d1_wdata,
  output logic        d1_we,
  output logic [3:0]  d1_be,
  input  logic        d1_rsp_valid,
  input  logic [31:0] d1_rsp_rdata
);

`ifdef DBUS_SPLIT_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic        sel_q, sel_d;
  logic        bypass_q, bypass_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic is_mmio;
  logic dec_err;
  logic sel_req_ready;
  logic sel_rsp_valid;
  logic [31:0] sel_rsp_rdata;

  assign is_mmio = (up_addr & MMIO_MASK) == MMIO_BASE;
  assign dec_err = ERR_EN && !is_mmio && (up_addr >= MEM_SIZE);

  // Only the selected port's handshake/response is ever looked at; the other port is ignored.
  assign sel_req_ready = sel_q ? d1_req_ready : d0_req_ready;
  assign sel_rsp_valid = sel_q ? d1_rsp_valid : d0_rsp_valid;
  assign sel_rsp_rdata = sel_q ? d1_rsp_rdata : d0_rsp_rdata;

  assign up_req_ready = (state_q == S_IDLE);
  assign up_rsp_valid = rsp_valid_q;
  assign up_rsp_rdata = rdata_q;
  assign up_rsp_err   = err_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    be_d        = be_q;
    sel_d       = sel_q;
    bypass_d    = bypass_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (up_req_valid) begin
          addr_d   = up_addr;
          wdata_d  = up_wdata;
          we_d     = up_we;
          be_d     = up_be;
          sel_d    = is_mmio;
          bypass_d = dec_err;
          // A decode error skips the downstream request and completes straight from WAIT.
          state_d  = dec_err ? S_WAIT : S_SEND;
        end
      end
      S_SEND: begin
        if (sel_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bypass_q) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rdata_d     = 32'h0;
          err_d       = 1'b1;
        end else if (sel_rsp_valid) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rdata_d     = we_q ? 32'h0 : sel_rsp_rdata;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      we_q        <= 1'b0;
      be_q        <= 4'h0;
      sel_q       <= 1'b0;
      bypass_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      be_q        <= be_d;
      sel_q       <= sel_d;
      bypass_q    <= bypass_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Downstream fields are driven only while a request is being offered, and only on the selected port.
  always_comb begin
    d0_req_valid = 1'b0;
    d0_addr      = 32'h0;
    d0_wdata     = 32'h0;
    d0_we        = 1'b0;
    d0_be        = 4'h0;
    d1_req_valid = 1'b0;
    d1_addr      = 32'h0;
    d1_wdata     = 32'h0;
    d1_we        = 1'b0;
    d1_be        = 4'h0;
    if (state_q == S_SEND) begin
      if (sel_q) begin
        d1_req_valid = 1'b1;
        d1_addr      = addr_q;
        d1_wdata     = wdata_q;
        d1_we        = we_q;
        d1_be        = be_q;
      end else begin
        d0_req_valid = 1'b1;
        d0_addr      = addr_q;
        d0_wdata     = wdata_q;
        d0_we        = we_q;
        d0_be        = be_q;
      end
    end
  end

endmodule

// File: tb/tb_dbus_split.sv
// Randomized scoreboard bench for dbus_split: a driver pushes expectations, a responder models both targets,
// and a monitor checks every upstream response. Honours DBUS_SPLIT_ERR_EN when defined.
`timescale 1ns/1ps
module tb_dbus_split;

`ifdef DBUS_SPLIT_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        up_req_valid, up_req_ready;
  logic [31:0] up_addr, up_wdata;
  logic        up_we;
  logic [3:0]  up_be;
  logic        up_rsp_valid;
  logic [31:0] up_rsp_rdata;
  logic        up_rsp_err;
  logic        d0_req_valid, d0_req_ready, d0_we, d0_rsp_valid;
  logic [31:0] d0_addr, d0_wdata, d0_rsp_rdata;
  logic [3:0]  d0_be;
  logic        d1_req_valid, d1_req_ready, d1_we, d1_rsp_valid;
  logic [31:0] d1_addr, d1_wdata, d1_rsp_rdata;
  logic [3:0]  d1_be;

  always #5 clk = ~clk;

  dbus_split dut (
    .clk(clk), .rst_n(rst_n),
    .up_req_valid(up_req_valid), .up_req_ready(up_req_ready),
    .up_addr(up_addr), .up_wdata(up_wdata), .up_we(up_we), .up_be(up_be),
    .up_rsp_valid(up_rsp_valid), .up_rsp_rdata(up_rsp_rdata), .up_rsp_err(up_rsp_err),
    .d0_req_valid(d0_req_valid), .d0_req_ready(d0_req_ready),
    .d0_addr(d0_addr), .d0_wdata(d0_wdata), .d0_we(d0_we), .d0_be(d0_be),
    .d0_rsp_valid(d0_rsp_valid), .d0_rsp_rdata(d0_rsp_rdata),
    .d1_req_valid(d1_req_valid), .d1_req_ready(d1_req_ready),
    .d1_addr(d1_addr), .d1_wdata(d1_wdata), .d1_we(d1_we), .d1_be(d1_be),
    .d1_rsp_valid(d1_rsp_valid), .d1_rsp_rdata(d1_rsp_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
    int          lat;
  } up_exp_t;

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  be;
    logic [31:0] rsp_data;
    int          acc_cyc;
  } dn_exp_t;

  up_exp_t up_q[$];
  dn_exp_t dn_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_last = 0;
  int last_rsp_cyc = -10;
  int rsp_count = 0;
  int force_stall = -1;
  int force_delay = -1;
  bit spur_en = 1'b0;
  bit busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference routing: MMIO is the 0x1xxx_xxxx window; with the error feature, anything else at or
  // above 64 KiB is a decode error (-1); otherwise it is data memory.
  function automatic int route(input logic [31:0] a);
    if (a[31:28] == 4'h1) return 1;
    if (ERR_EN && a >= 32'h0001_0000) return -1;
    return 0;
  endfunction

  function automatic logic dv(input int p);
    return (p == 1) ? d1_req_valid : d0_req_valid;
  endfunction
  function automatic logic [31:0] daddr(input int p);
    return (p == 1) ? d1_addr : d0_addr;
  endfunction
  function automatic logic [31:0] dwdata(input int p);
    return (p == 1) ? d1_wdata : d0_wdata;
  endfunction
  function automatic logic dwe(input int p);
    return (p == 1) ? d1_we : d0_we;
  endfunction
  function automatic logic [3:0] dbe(input int p);
    return (p == 1) ? d1_be : d0_be;
  endfunction

  task automatic set_ready(input int p, input logic v);
    if (p == 1) d1_req_ready = v; else d0_req_ready = v;
  endtask
  task automatic set_rsp(input int p, input logic v, input logic [31:0] data);
    if (p == 1) begin d1_rsp_valid = v; d1_rsp_rdata = data; end
    else begin d0_rsp_valid = v; d0_rsp_rdata = data; end
  endtask

  // Downstream target model shared by both ports (only one transaction is ever in flight).
  task automatic serve(input int p);
    dn_exp_t e;
    logic [31:0] a, w;
    logic we;
    logic [3:0] be;
    int stall, dly;
    busy = 1'b1;
    a = daddr(p); w = dwdata(p); we = dwe(p); be = dbe(p);
    e.rsp_data = 32'h0;
    if (dn_q.size() == 0) begin
      fail_now("dn_unexpected_request");
    end else begin
      e = dn_q.pop_front();
      chk("dn_port", p, e.port);
      chk("dn_addr", a, e.addr);
      chk("dn_wdata", w, e.wdata);
      chk("dn_we", we, e.we);
      chk("dn_be", be, e.be);
      chk("dn_latency", cyc - e.acc_cyc, 0);
    end
    stall = (force_stall >= 0) ? force_stall : int'($urandom_range(0, 2));
    for (int i = 0; i < stall; i++) begin
      set_ready(p, 1'b0);
      @(negedge clk);
      chk("stall_valid", dv(p), 1'b1);
      chk("stall_addr", daddr(p), a);
      chk("stall_wdata", dwdata(p), w);
      chk("stall_we", dwe(p), we);
      chk("stall_be", dbe(p), be);
      chk("stall_up_ready", up_req_ready, 1'b0);
    end
    set_ready(p, 1'b1);
    @(negedge clk);
    set_ready(p, 1'b0);
    dly = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
    for (int i = 0; i < dly; i++) begin
      set_rsp(1 - p, spur_en && (i == 0), 32'hBAD0_BAD0);
      @(negedge clk);
      chk("wait_no_up_rsp", up_rsp_valid, 1'b0);
    end
    set_rsp(1 - p, 1'b0, 32'h0);
    set_rsp(p, 1'b1, e.rsp_data);
    @(negedge clk);
    set_rsp(p, 1'b0, 32'h0);
    busy = 1'b0;
  endtask

  initial begin
    d0_req_ready = 1'b0; d1_req_ready = 1'b0;
    d0_rsp_valid = 1'b0; d1_rsp_valid = 1'b0;
    d0_rsp_rdata = 32'h0; d1_rsp_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("dn_one_hot", {31'h0, d0_req_valid & d1_req_valid}, 32'h0);
        if (d0_req_valid || d1_req_valid) serve(d1_req_valid ? 1 : 0);
      end
    end
  end

  // Monitor: every upstream response must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && up_rsp_valid) begin
      up_exp_t e;
      last_rsp_cyc = cyc;
      rsp_count++;
      $display("rsp %0d: cycle %0d rdata=0x%08h err=%0b", rsp_count, cyc, up_rsp_rdata, up_rsp_err);
      if (up_q.size() == 0) begin
        fail_now("up_unexpected_response");
      end else begin
        e = up_q.pop_front();
        chk("up_rdata", up_rsp_rdata, e.rdata);
        chk("up_err", up_rsp_err, e.err);
        chk("up_ready_with_rsp", up_req_ready, 1'b1);
        if (e.lat >= 0) chk("up_latency", cyc - e.acc_cyc, e.lat);
      end
    end
  end

  // Presents a request and returns right after the accepting edge, leaving valid high.
  task automatic issue(input logic [31:0] a, input logic we, input logic [31:0] w, input logic [3:0] be,
                       input logic [31:0] rsp_data, input bit check_lat);
    up_exp_t ue;
    dn_exp_t de;
    int r, n;
    @(negedge clk);
    up_req_valid = 1'b1; up_addr = a; up_we = we; up_wdata = w; up_be = be;
    n = 0;
    while (!up_req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!up_req_ready) begin
      fail_now("up_accept_timeout");
      return;
    end
    @(posedge clk);
    #1;
    acc_last = cyc;
    r = route(a);
    // Accept at edge T: normal minimum round trip is seen two cycles later, decode error one cycle later.
    ue.rdata = (r < 0 || we) ? 32'h0 : rsp_data;
    ue.err = (r < 0);
    ue.acc_cyc = acc_last;
    ue.lat = check_lat ? ((r < 0) ? 1 : 2) : -1;
    up_q.push_back(ue);
    if (r >= 0) begin
      de.port = r; de.addr = a; de.wdata = w; de.we = we; de.be = be;
      de.rsp_data = rsp_data; de.acc_cyc = acc_last;
      dn_q.push_back(de);
    end
    $display("req: cycle %0d addr=0x%08h we=%0b wdata=0x%08h be=%04b route=%0d", acc_last, a, we, w, be, r);
  endtask

  task automatic idle();
    @(negedge clk);
    up_req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((up_q.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (up_q.size() != 0 || busy) begin
      fail_now("drain_timeout");
      up_q.delete();
      dn_q.delete();
    end
  endtask

  initial begin
    logic [31:0] a, w;
    int sel;
    rst_n = 1'b0;
    up_req_valid = 1'b0; up_addr = 32'h0; up_wdata = 32'h0; up_we = 1'b0; up_be = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_up_ready", up_req_ready, 1'b1);
    chk("rst_up_rsp_valid", up_rsp_valid, 1'b0);
    chk("rst_up_rdata", up_rsp_rdata, 32'h0);
    chk("rst_up_err", up_rsp_err, 1'b0);
    chk("rst_d0_valid", d0_req_valid, 1'b0);
    chk("rst_d1_valid", d1_req_valid, 1'b0);
    chk("rst_d0_addr", d0_addr, 32'h0);
    rst_n = 1'b1;

    // Minimum-latency load to data memory.
    force_stall = 0; force_delay = 0;
    issue(32'h0000_0040, 1'b0, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b1);
    idle(); drain();

    // Stalled store to MMIO.
    force_stall = 3; force_delay = 1;
    issue(32'h1000_0004, 1'b1, 32'h0000_00A5, 4'b0001, 32'h1234_5678, 1'b0);
    idle(); drain();

    // Back-to-back loads: second must be taken in the first response's cycle.
    force_stall = -1; force_delay = -1;
    issue(32'h0000_0000, 1'b0, 32'h0, 4'hF, 32'h1111_0000, 1'b0);
    issue(32'h1000_0000, 1'b0, 32'h0, 4'hF, 32'h2222_0000, 1'b0);
    chk("b2b_accept_in_rsp_cycle", acc_last - last_rsp_cyc, 1);
    idle(); drain();

    // Spurious response from the unselected port.
    force_stall = 0; force_delay = 3; spur_en = 1'b1;
    issue(32'h1000_0008, 1'b0, 32'h0, 4'hF, 32'h5555_AAAA, 1'b0);
    idle(); drain();
    spur_en = 1'b0;

    // Reset while waiting for a response abandons the transaction.
    force_stall = 0; force_delay = 6;
    issue(32'h1000_0010, 1'b0, 32'h0, 4'hF, 32'h6666_6666, 1'b0);
    idle();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_up_rsp_valid", up_rsp_valid, 1'b0);
    chk("arst_up_rdata", up_rsp_rdata, 32'h0);
    chk("arst_up_err", up_rsp_err, 1'b0);
    chk("arst_d1_valid", d1_req_valid, 1'b0);
    chk("arst_d0_valid", d0_req_valid, 1'b0);
    chk("arst_up_ready", up_req_ready, 1'b1);
    up_q.delete();
    dn_q.delete();
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    force_stall = 0; force_delay = 0;
    issue(32'h0000_0100, 1'b0, 32'h0, 4'hF, 32'h0BAD_CAFE, 1'b1);
    idle(); drain();

    // Address outside both regions.
    issue(32'h2000_0000, 1'b0, 32'h0, 4'hF, 32'h7777_7777, 1'b1);
    idle(); drain();

    // Randomized traffic across all regions.
    force_stall = -1; force_delay = -1;
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: a = {16'h0, $urandom_range(0, 16'hFFFF)} & 32'hFFFF_FFFC;
        1: a = 32'h1000_0000 | ({$urandom} & 32'h0FFF_FFFC);
        2: a = 32'h2000_0000 | ({$urandom} & 32'h0FFF_FFFC);
        default: a = 32'h0001_0000 + ({$urandom} & 32'h0000_FFFC);
      endcase
      w = $urandom;
      issue(a, 1'($urandom_range(0, 1)), w, 4'($urandom_range(0, 15)), $urandom, 1'b0);
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle(); drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
